// File: rtl/fc_layer_sequencer_pkg.sv
// Shared definitions for the serial fully connected layer sequencer:
// FSM state encoding, default sizes and the output activation function.
// Build option: define FC_SEQ_SATURATE_EN to clamp positive results to the
// activation range; without it positive results are truncated (legacy FC).
package fc_layer_sequencer_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_BIAS  = 3'd1,
    S_MAC   = 3'd2,
    S_DRAIN = 3'd3,
    S_EMIT  = 3'd4,
    S_DONE  = 3'd5
  } fc_state_e;

  localparam int FC_INPUT_SIZE_DEF  = 160;
  localparam int FC_OUTPUT_SIZE_DEF = 64;
  localparam int FC_ACTIV_BITS_DEF  = 8;
  localparam int FC_ACC_BITS_DEF    = 24;

`ifdef FC_SEQ_SATURATE_EN
  localparam bit FC_SAT_EN = 1'b1;
`else
  localparam bit FC_SAT_EN = 1'b0;
`endif

  // ReLU on a sign-extended accumulator; positive values either clamp to
  // 2^bits-1 or keep only the low bits, depending on the build option.
  function automatic logic [31:0] fc_act(input logic signed [63:0] i_acc,
                                         input int unsigned        i_bits);
    logic [63:0] w_max;
    w_max = (64'd1 << i_bits) - 64'd1;
    if (i_acc < 64'sd0) begin
      fc_act = 32'd0;
    end else if (FC_SAT_EN && (i_acc > $signed(w_max))) begin
      fc_act = w_max[31:0];
    end else begin
      fc_act = i_acc[31:0] & w_max[31:0];
    end
  endfunction

endpackage

// File: rtl/fc_layer_sequencer_if.sv
// Memory read ports (weights, biases) and the output activation stream of the
// FC layer sequencer. master = sequencer side, slave = memories/consumer side.
interface fc_layer_sequencer_if #(
  parameter int ACTIV_BITS = 8,
  parameter int W_AW       = 14,
  parameter int B_AW       = 6,
  parameter int O_W        = 6
);
  logic                  w_rd_en;
  logic [W_AW-1:0]       w_rd_addr;
  logic [ACTIV_BITS-1:0] w_rd_data;
  logic                  b_rd_en;
  logic [B_AW-1:0]       b_rd_addr;
  logic [ACTIV_BITS-1:0] b_rd_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [O_W-1:0]        out_idx;
  logic [ACTIV_BITS-1:0] out_data;

  modport master (
    output w_rd_en, w_rd_addr, input w_rd_data,
    output b_rd_en, b_rd_addr, input b_rd_data,
    output out_valid, out_idx, out_data, input out_ready
  );

  modport slave (
    input w_rd_en, w_rd_addr, output w_rd_data,
    input b_rd_en, b_rd_addr, output b_rd_data,
    input out_valid, out_idx, out_data, output out_ready
  );
endinterface

// File: rtl/fc_layer_sequencer_mac_unit.sv
// Single signed multiply-accumulate for the FC sequencer. A load replaces the
// accumulator with the sign-extended bias; an accumulate adds
// sext(weight) * zext(activation). The next-state value is exported so the
// sequencer can apply the activation in the same cycle as the last product.
module fc_mac_unit #(
  parameter int ACTIV_BITS = 8,
  parameter int ACC_BITS   = 24
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_ld,
  input  logic                  i_en,
  input  logic [ACTIV_BITS-1:0] i_bias,
  input  logic [ACTIV_BITS-1:0] i_w,
  input  logic [ACTIV_BITS-1:0] i_x,
  output logic [ACC_BITS-1:0]   o_acc_nxt
);
  localparam int P_W = 2 * ACTIV_BITS + 1;

  logic [ACC_BITS-1:0]   r_acc;
  logic [ACC_BITS-1:0]   w_acc_nxt;
  logic signed [P_W-1:0] w_x_ext;
  logic signed [P_W-1:0] w_w_ext;
  logic signed [P_W-1:0] w_prod;

  // Activation is unsigned (zero-extend), weight is signed (sign-extend).
  assign w_x_ext = $signed({{(P_W - ACTIV_BITS){1'b0}}, i_x});
  assign w_w_ext = $signed({{(P_W - ACTIV_BITS){i_w[ACTIV_BITS-1]}}, i_w});
  assign w_prod  = w_x_ext * w_w_ext;

  // Next accumulator value: bias load wins over accumulate; wraps mod 2^ACC_BITS.
  always_comb begin
    w_acc_nxt = r_acc;
    if (i_ld) begin
      w_acc_nxt = {{(ACC_BITS - ACTIV_BITS){i_bias[ACTIV_BITS-1]}}, i_bias};
    end else if (i_en) begin
      w_acc_nxt = r_acc + {{(ACC_BITS - P_W){w_prod[P_W-1]}}, w_prod};
    end else begin
      w_acc_nxt = r_acc;
    end
  end

  // Accumulator register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc <= {ACC_BITS{1'b0}};
    end else begin
      r_acc <= w_acc_nxt;
    end
  end

  assign o_acc_nxt = w_acc_nxt;
endmodule

// File: rtl/fc_layer_sequencer.sv
// Time-multiplexed controller for one fully connected layer. Latches the input
// vector on start, then per neuron: read bias, read INPUT_SIZE weights, drain
// the last product, emit ReLU(acc) on a valid/ready stream. One MAC total.
// Build option: FC_SEQ_SATURATE_EN (see fc_layer_sequencer_pkg).
module fc_layer_sequencer
  import fc_layer_sequencer_pkg::*;
#(
  parameter int INPUT_SIZE  = FC_INPUT_SIZE_DEF,
  parameter int OUTPUT_SIZE = FC_OUTPUT_SIZE_DEF,
  parameter int ACTIV_BITS  = FC_ACTIV_BITS_DEF,
  parameter int ACC_BITS    = FC_ACC_BITS_DEF
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             i_start,
  input  logic                             i_abort,
  input  logic [INPUT_SIZE*ACTIV_BITS-1:0] i_data_in,
  output logic                             o_busy,
  output logic                             o_done,
  fc_layer_sequencer_if.master             bus
);
  localparam int W_AW = $clog2(OUTPUT_SIZE * INPUT_SIZE);
  localparam int B_AW = $clog2(OUTPUT_SIZE);
  localparam int O_W  = (OUTPUT_SIZE > 1) ? $clog2(OUTPUT_SIZE) : 1;
  localparam int J_W  = (INPUT_SIZE > 1) ? $clog2(INPUT_SIZE) : 1;

  fc_state_e                        r_state;
  logic [INPUT_SIZE*ACTIV_BITS-1:0] r_x_vec;
  logic [O_W-1:0]                   r_o;
  logic [J_W-1:0]                   r_j;
  logic [J_W-1:0]                   r_jd;
  logic                             r_ld;
  logic                             r_acc_en;
  logic                             r_busy;
  logic                             r_done;
  logic                             r_w_rd_en;
  logic [W_AW-1:0]                  r_w_rd_addr;
  logic                             r_b_rd_en;
  logic [B_AW-1:0]                  r_b_rd_addr;
  logic                             r_out_valid;
  logic [O_W-1:0]                   r_out_idx;
  logic [ACTIV_BITS-1:0]            r_out_data;

  logic [ACC_BITS-1:0]              w_acc_nxt;
  logic [63:0]                      w_acc_sx;
  logic [ACTIV_BITS-1:0]            w_x_sel;

  // Activation paired with the weight returning this cycle (index delayed by one).
  assign w_x_sel  = r_x_vec[int'(r_jd) * ACTIV_BITS +: ACTIV_BITS];
  assign w_acc_sx = {{(64 - ACC_BITS){w_acc_nxt[ACC_BITS-1]}}, w_acc_nxt};

  fc_mac_unit #(
    .ACTIV_BITS (ACTIV_BITS),
    .ACC_BITS   (ACC_BITS)
  ) u_mac (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_ld      (r_ld),
    .i_en      (r_acc_en),
    .i_bias    (bus.b_rd_data),
    .i_w       (bus.w_rd_data),
    .i_x       (w_x_sel),
    .o_acc_nxt (w_acc_nxt)
  );

  // Sequencer FSM: counters, read strobes/addresses, output handshake, done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_x_vec     <= {(INPUT_SIZE*ACTIV_BITS){1'b0}};
      r_o         <= {O_W{1'b0}};
      r_j         <= {J_W{1'b0}};
      r_jd        <= {J_W{1'b0}};
      r_ld        <= 1'b0;
      r_acc_en    <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_w_rd_en   <= 1'b0;
      r_w_rd_addr <= {W_AW{1'b0}};
      r_b_rd_en   <= 1'b0;
      r_b_rd_addr <= {B_AW{1'b0}};
      r_out_valid <= 1'b0;
      r_out_idx   <= {O_W{1'b0}};
      r_out_data  <= {ACTIV_BITS{1'b0}};
    end else if (i_abort && (r_state != S_IDLE)) begin
      // Cancel: drop every strobe and the pending output, never pulse done.
      r_state     <= S_IDLE;
      r_ld        <= 1'b0;
      r_acc_en    <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_w_rd_en   <= 1'b0;
      r_b_rd_en   <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      // Read data arrives one cycle after its strobe; align load/accumulate.
      r_ld     <= r_b_rd_en;
      r_acc_en <= r_w_rd_en;
      r_jd     <= r_j;
      r_done   <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_x_vec     <= i_data_in;
            r_o         <= {O_W{1'b0}};
            r_busy      <= 1'b1;
            r_b_rd_en   <= 1'b1;
            r_b_rd_addr <= {B_AW{1'b0}};
            r_state     <= S_BIAS;
          end else begin
            r_state     <= S_IDLE;
          end
        end
        S_BIAS: begin
          r_b_rd_en   <= 1'b0;
          r_w_rd_en   <= 1'b1;
          r_w_rd_addr <= W_AW'(32'(r_o) * INPUT_SIZE);
          r_j         <= {J_W{1'b0}};
          r_state     <= S_MAC;
        end
        S_MAC: begin
          if (r_j == J_W'(INPUT_SIZE - 1)) begin
            r_w_rd_en <= 1'b0;
            r_state   <= S_DRAIN;
          end else begin
            r_j         <= r_j + J_W'(1'b1);
            r_w_rd_addr <= r_w_rd_addr + W_AW'(1'b1);
          end
        end
        S_DRAIN: begin
          // w_acc_nxt already includes the last product.
          r_out_valid <= 1'b1;
          r_out_idx   <= r_o;
          r_out_data  <= ACTIV_BITS'(fc_act($signed(w_acc_sx), unsigned'(ACTIV_BITS)));
          r_state     <= S_EMIT;
        end
        S_EMIT: begin
          if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            if (r_o == O_W'(OUTPUT_SIZE - 1)) begin
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end else begin
              r_o         <= r_o + O_W'(1'b1);
              r_b_rd_en   <= 1'b1;
              r_b_rd_addr <= B_AW'(r_o + O_W'(1'b1));
              r_state     <= S_BIAS;
            end
          end else begin
            r_state <= S_EMIT;
          end
        end
        S_DONE: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_busy      <= 1'b0;
          r_w_rd_en   <= 1'b0;
          r_b_rd_en   <= 1'b0;
          r_out_valid <= 1'b0;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

  assign o_busy        = r_busy;
  assign o_done        = r_done;
  assign bus.w_rd_en   = r_w_rd_en;
  assign bus.w_rd_addr = r_w_rd_addr;
  assign bus.b_rd_en   = r_b_rd_en;
  assign bus.b_rd_addr = r_b_rd_addr;
  assign bus.out_valid = r_out_valid;
  assign bus.out_idx   = r_out_idx;
  assign bus.out_data  = r_out_data;
endmodule

// File: tb/tb_fc_layer_sequencer.sv
// Scoreboard bench for fc_layer_sequencer (INPUT_SIZE=4, OUTPUT_SIZE=2, ACC_BITS=18).
// Expected activations come from a plain-integer dot-product model; a monitor
// pops and compares on every output handshake.
module tb_fc_layer_sequencer;
  localparam int IS  = 4;
  localparam int OS  = 2;
  localparam int AB  = 8;
  localparam int ACC = 18;
  localparam int LAT = IS + 3;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            start = 1'b0;
  logic            abort = 1'b0;
  logic [IS*AB-1:0] data_in = '0;
  logic            busy;
  logic            done;

  fc_layer_sequencer_if #(.ACTIV_BITS(AB), .W_AW(3), .B_AW(1), .O_W(1)) bus_if ();

  fc_layer_sequencer #(
    .INPUT_SIZE(IS), .OUTPUT_SIZE(OS), .ACTIV_BITS(AB), .ACC_BITS(ACC)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_start   (start),
    .i_abort   (abort),
    .i_data_in (data_in),
    .o_busy    (busy),
    .o_done    (done),
    .bus       (bus_if)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int c0 = 0;
  int xv[IS];
  int wv[OS*IS];
  int bv[OS];

  typedef struct {
    int idx;
    int data;
    int first;
  } exp_t;
  exp_t sb[$];

  // free-running cycle counter
  always @(posedge clk) cyc <= cyc + 1;

  // 1-cycle-latency weight and bias memories
  always @(posedge clk) begin
    if (bus_if.w_rd_en) bus_if.w_rd_data <= 8'(wv[bus_if.w_rd_addr]);
    if (bus_if.b_rd_en) bus_if.b_rd_data <= 8'(bv[bus_if.b_rd_addr]);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: bias + dot product, wrapped to ACC bits, then ReLU and clamp/truncate.
  function automatic int model(input int o);
    int acc;
    int m;
    acc = bv[o];
    for (int j = 0; j < IS; j++) acc += wv[o*IS + j] * xv[j];
    m = 1 << ACC;
    acc = ((acc % m) + m) % m;
    if (acc >= m / 2) acc -= m;
    if (acc < 0) return 0;
`ifdef FC_SEQ_SATURATE_EN
    return (acc > 255) ? 255 : acc;
`else
    return acc % 256;
`endif
  endfunction

  // Output monitor: stability while stalled, no reads while stalled, scoreboard compare.
  bit         in_emit = 1'b0;
  int         first_k = 0;
  logic       held_idx;
  logic [7:0] held_data;
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        in_emit = 1'b0;
      end else if (bus_if.out_valid) begin
        if (!in_emit) begin
          in_emit   = 1'b1;
          first_k   = cyc - c0 + 1;
          held_idx  = bus_if.out_idx;
          held_data = bus_if.out_data;
        end else begin
          chk("hold_idx", bus_if.out_idx, held_idx);
          chk("hold_data", bus_if.out_data, held_data);
        end
        if (!bus_if.out_ready) begin
          chk("no_rd_stall", {bus_if.w_rd_en, bus_if.b_rd_en}, 0);
        end else begin
          in_emit = 1'b0;
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_out: idx %0d data %0d with empty scoreboard",
                     bus_if.out_idx, bus_if.out_data);
          end else begin
            e = sb.pop_front();
            chk("out_idx", bus_if.out_idx, e.idx);
            chk("out_data", bus_if.out_data, e.data);
            if (e.first >= 0) chk("first_valid_cycle", first_k, e.first);
          end
        end
      end
    end
  end

  // One layer run. Cycle k counts from 1 = first cycle after the start edge.
  task automatic launch(input int stall, input int restart_k, input int abort_k,
                        input int quit_k, input int n_exp, input bit rnd_rdy,
                        input bit chk_time);
    bit got_done;
    int k;
    for (int j = 0; j < IS; j++) data_in[j*AB +: AB] = 8'(xv[j]);
    for (int o = 0; o < n_exp; o++) begin
      exp_t e;
      e.idx   = o;
      e.data  = model(o);
      e.first = chk_time ? ((o + 1) * LAT + ((o > 0) ? stall : 0)) : -1;
      sb.push_back(e);
    end
    bus_if.out_ready = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    c0 = cyc;
    got_done = 1'b0;
    for (int n = 0; n < 400; n++) begin
      k = cyc - c0 + 1;
      abort = (k == abort_k);
      if (k == restart_k) begin
        start = 1'b1;
        for (int j = 0; j < IS; j++) data_in[j*AB +: AB] = 8'($urandom);
      end else begin
        start = 1'b0;
      end
      if (rnd_rdy) bus_if.out_ready = 1'($urandom_range(0, 1));
      else         bus_if.out_ready = !(k >= LAT && k < LAT + stall);
      if (k == 1) chk("busy_after_start", busy, 1);
      if (abort_k > 0 && k == abort_k + 1)
        chk("abort_idle", {busy, bus_if.out_valid, bus_if.w_rd_en, bus_if.b_rd_en}, 0);
      if (done) begin
        got_done = 1'b1;
        if (chk_time) chk("done_cycle", k, OS * LAT + stall + 1);
        break;
      end
      if (k == quit_k) break;
      @(posedge clk); #1;
    end
    abort = 1'b0;
    start = 1'b0;
    if (quit_k < 0) begin
      bus_if.out_ready = 1'b1;
      chk("done_seen", got_done, 1);
      @(posedge clk); #1;
      chk("idle_after_done", {busy, done}, 0);
      chk("sb_empty", sb.size(), 0);
    end else if (abort_k > 0) begin
      bus_if.out_ready = 1'b1;
      chk("no_done_after_abort", got_done, 0);
      chk("sb_empty_abort", sb.size(), 0);
    end
  endtask

  task automatic set_case1();
    xv = '{1, 2, 3, 4};
    for (int j = 0; j < IS; j++) begin
      wv[j]      = 1;
      wv[IS + j] = -1;
    end
    bv = '{0, 2};
  endtask

  // time bound for the whole run
  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus_if.out_ready = 1'b1;
    set_case1();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_valid", bus_if.out_valid, 0);
    chk("rst_strobes", {bus_if.w_rd_en, bus_if.b_rd_en}, 0);
    chk("rst_addrs", {bus_if.w_rd_addr, bus_if.b_rd_addr}, 0);
    chk("rst_out", {bus_if.out_idx, bus_if.out_data}, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // case 1: basic two-neuron run with latency
    set_case1();
    launch(0, -1, -1, -1, OS, 1'b0, 1'b1);

    // case 2: large positive accumulator (clamp or truncate)
    for (int j = 0; j < IS; j++) begin
      xv[j]      = 255;
      wv[j]      = 127;
      wv[IS + j] = $urandom_range(0, 255) - 128;
    end
    bv[0] = 0;
    bv[1] = $urandom_range(0, 255) - 128;
    launch(0, -1, -1, -1, OS, 1'b0, 1'b1);

    // case 3: consumer stalls 5 cycles at neuron 0
    set_case1();
    launch(5, -1, -1, -1, OS, 1'b0, 1'b1);

    // case 4: second start with other data mid-run is ignored
    set_case1();
    launch(0, 3, -1, -1, OS, 1'b0, 1'b1);

    // case 5: abort during MAC of neuron 1, then fresh run
    set_case1();
    launch(0, -1, 10, 25, 1, 1'b0, 1'b1);
    launch(0, -1, -1, -1, OS, 1'b0, 1'b1);

    // case 6: async reset while neuron 0 is being emitted, then fresh run
    launch(20, -1, -1, 9, 1, 1'b0, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_outputs", {bus_if.out_valid, busy, done}, 0);
    bus_if.out_ready = 1'b1;
    sb.delete();
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    launch(0, -1, -1, -1, OS, 1'b0, 1'b1);

    // randomized runs, alternating fixed and random consumer readiness
    for (int r = 0; r < 12; r++) begin
      for (int j = 0; j < IS; j++) xv[j] = $urandom_range(0, 255);
      for (int i = 0; i < OS*IS; i++) wv[i] = $urandom_range(0, 255) - 128;
      for (int o = 0; o < OS; o++) bv[o] = $urandom_range(0, 255) - 128;
      launch(0, -1, -1, -1, OS, 1'(r % 2), 1'((r % 2) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
